// File: rtl/multicycle_control_v2_pkg.sv
// multicycle_control_v2_pkg: shared encodings for the multicycle control FSM
package multicycle_control_v2_pkg;
  localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_ADDI = 4'd2, OP_SUB = 4'd3,
                         OP_LR = 4'd5, OP_SR = 4'd6, OP_BLEQ = 4'd8, OP_JMP = 4'd9,
                         OP_HALT = 4'd15;
  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_IF        = 4'd1,
    S_ID        = 4'd2,
    S_REG_X     = 4'd3,
    S_ADDI      = 4'd4,
    S_ALU_WB    = 4'd5,
    S_LR_ADDR   = 4'd6,
    S_SR_ADDR   = 4'd7,
    S_MEM_LOAD  = 4'd8,
    S_MEM_STORE = 4'd9,
    S_MEM_WB    = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_HALT      = 4'd14,
    S_ERROR     = 4'd15
  } state_t;
  localparam logic [2:0] ALU_OP_ADD = 3'd0, ALU_OP_SUB = 3'd1;
  localparam logic [1:0] PC_SELECT_RESET = 2'd0, PC_SELECT_ALU = 2'd1,
                         PC_SELECT_ALU_BUF = 2'd2, PC_SELECT_JUMP = 2'd3;
  localparam logic ALU_A_PC = 1'b0, ALU_A_REG = 1'b1;
  localparam logic [1:0] ALU_B_REG = 2'd0, ALU_B_PC4 = 2'd1, ALU_B_IMM = 2'd2, ALU_B_BRANCH = 2'd3;
  localparam logic DATA_SELECT_ALU = 1'b0, DATA_SELECT_MEM = 1'b1;
  localparam logic REG_DST_RN = 1'b0, REG_DST_RD = 1'b1;
  // states that wait on mem_ready and are therefore watched by the timeout counter
  function automatic logic is_mem_wait(state_t s);
    return (s == S_IF) || (s == S_MEM_LOAD) || (s == S_MEM_STORE);
  endfunction
endpackage

// File: rtl/multicycle_control_v2_if.sv
// multicycle_control_v2_if: controller <-> datapath strobe and status bundle
interface multicycle_control_v2_if #(
  parameter int WIDTH_OPCODE   = 4,
  parameter int ALU_OP_WIDTH   = 3,
  parameter int NUM_STATE_BITS = 4
);
  logic [WIDTH_OPCODE-1:0]   opcode;
  logic                      alu_zero;
  logic                      alu_neg;
  logic                      mem_ready;
  logic                      RegDst;
  logic                      ALUSrcA;
  logic                      RegWrite;
  logic                      MemToReg;
  logic                      IRWrite;
  logic                      MemWrite;
  logic                      MemRead;
  logic                      PCWrite;
  logic                      PCWriteCond;
  logic                      mem_select;
  logic [1:0]                ALUSrcB;
  logic [ALU_OP_WIDTH-1:0]   ALUOp;
  logic [1:0]                PCSource;
  logic                      error;
  logic                      halted;
  logic [NUM_STATE_BITS-1:0] state_out;
  modport master (
    input  opcode, alu_zero, alu_neg, mem_ready,
    output RegDst, ALUSrcA, RegWrite, MemToReg, IRWrite, MemWrite, MemRead, PCWrite,
           PCWriteCond, mem_select, ALUSrcB, ALUOp, PCSource, error, halted, state_out
  );
  modport slave (
    output opcode, alu_zero, alu_neg, mem_ready,
    input  RegDst, ALUSrcA, RegWrite, MemToReg, IRWrite, MemWrite, MemRead, PCWrite,
           PCWriteCond, mem_select, ALUSrcB, ALUOp, PCSource, error, halted, state_out
  );
endinterface

// File: rtl/multicycle_control_v2_mem_wait_timer.sv
// multicycle_control_v2_mem_wait_timer: counts wait cycles of one memory access and flags the limit
module multicycle_control_v2_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] r_count;
  assign o_expired = (MEM_TIMEOUT != 0) && (r_count == CW'(MEM_TIMEOUT));
  // count stalled cycles, restarting on reset or whenever the FSM changes state
  always_ff @(posedge clk) begin
    if (!reset || i_clear) r_count <= '0;
    else if (i_enable && !o_expired) r_count <= r_count + CW'(1);
  end
endmodule

// File: rtl/multicycle_control_v2.sv
// multicycle_control_v2: multicycle datapath control FSM with memory wait states, watchdog and sticky halt/error
module multicycle_control_v2
  import multicycle_control_v2_pkg::*;
#(
  parameter int WIDTH_OPCODE   = 4,
  parameter int ALU_OP_WIDTH   = 3,
  parameter int NUM_STATE_BITS = 4,
  parameter int MEM_WAIT_EN    = 1,
  parameter int MEM_TIMEOUT    = 15
) (
  input logic                   clk,
  input logic                   reset,
  multicycle_control_v2_if.master bus
);
  state_t r_state, w_next;
  logic   r_error, r_halted;
  logic   w_ready, w_expired, w_timeout;
  assign w_ready   = (MEM_WAIT_EN == 0) || bus.mem_ready;
  assign w_timeout = is_mem_wait(r_state) && !w_ready && w_expired;
  assign bus.error     = r_error;
  assign bus.halted    = r_halted;
  assign bus.state_out = NUM_STATE_BITS'(r_state);
  multicycle_control_v2_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_next != r_state),
    .i_enable  (is_mem_wait(r_state) && !w_ready),
    .o_expired (w_expired)
  );
  // next-state selection: opcode dispatch in ID, memory waits hold until ready or timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:     w_next = S_IF;
      S_IF:        w_next = w_ready ? S_ID : (w_timeout ? S_ERROR : S_IF);
      S_ID: begin
        case (bus.opcode)
          WIDTH_OPCODE'(OP_NOP):                        w_next = S_IF;
          WIDTH_OPCODE'(OP_ADD), WIDTH_OPCODE'(OP_SUB): w_next = S_REG_X;
          WIDTH_OPCODE'(OP_ADDI):                       w_next = S_ADDI;
          WIDTH_OPCODE'(OP_LR):                         w_next = S_LR_ADDR;
          WIDTH_OPCODE'(OP_SR):                         w_next = S_SR_ADDR;
          WIDTH_OPCODE'(OP_BLEQ):                       w_next = S_BRANCH;
          WIDTH_OPCODE'(OP_JMP):                        w_next = S_JUMP;
          WIDTH_OPCODE'(OP_HALT):                       w_next = S_HALT;
          default:                                      w_next = S_ERROR;
        endcase
      end
      S_REG_X, S_ADDI:                          w_next = S_ALU_WB;
      S_LR_ADDR:                                w_next = S_MEM_LOAD;
      S_SR_ADDR:                                w_next = S_MEM_STORE;
      S_MEM_LOAD:  w_next = w_ready ? S_MEM_WB : (w_timeout ? S_ERROR : S_MEM_LOAD);
      S_MEM_STORE: w_next = w_ready ? S_IF : (w_timeout ? S_ERROR : S_MEM_STORE);
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP:     w_next = S_IF;
      S_HALT:                                   w_next = S_HALT;
      default:                                  w_next = S_ERROR;
    endcase
  end
  // state register with sticky error/halt flags; only reset leaves HALT or ERROR
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_RESET;
      r_error  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_error  <= r_error | (w_next == S_ERROR);
      r_halted <= r_halted | (w_next == S_HALT);
    end
  end
  // Moore strobe decode; only the fetch completion strobes follow mem_ready
  always_comb begin
    bus.RegDst      = 1'b0;
    bus.ALUSrcA     = ALU_A_PC;
    bus.RegWrite    = 1'b0;
    bus.MemToReg    = DATA_SELECT_ALU;
    bus.IRWrite     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemRead     = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.mem_select  = 1'b0;
    bus.ALUSrcB     = ALU_B_REG;
    bus.ALUOp       = ALU_OP_WIDTH'(ALU_OP_ADD);
    bus.PCSource    = PC_SELECT_RESET;
    case (r_state)
      S_RESET: begin
        bus.MemRead  = 1'b1;
        bus.PCWrite  = 1'b1;
        bus.PCSource = PC_SELECT_RESET;
      end
      S_IF: begin
        bus.MemRead  = 1'b1;
        bus.ALUSrcA  = ALU_A_PC;
        bus.ALUSrcB  = ALU_B_PC4;
        bus.PCSource = PC_SELECT_ALU;
        bus.IRWrite  = w_ready;
        bus.PCWrite  = w_ready;
      end
      S_ID: begin
        bus.ALUSrcA = ALU_A_PC;
        bus.ALUSrcB = ALU_B_BRANCH;
      end
      S_REG_X: begin
        bus.ALUSrcA = ALU_A_REG;
        bus.ALUSrcB = ALU_B_REG;
        bus.RegDst  = REG_DST_RD;
        bus.ALUOp   = ALU_OP_WIDTH'((bus.opcode == WIDTH_OPCODE'(OP_SUB)) ? ALU_OP_SUB : ALU_OP_ADD);
      end
      S_ADDI: begin
        bus.ALUSrcA = ALU_A_REG;
        bus.ALUSrcB = ALU_B_IMM;
        bus.RegDst  = REG_DST_RN;
      end
      S_ALU_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemToReg = DATA_SELECT_ALU;
        bus.RegDst   = (bus.opcode == WIDTH_OPCODE'(OP_ADDI)) ? REG_DST_RN : REG_DST_RD;
      end
      S_LR_ADDR, S_SR_ADDR: begin
        bus.ALUSrcA = ALU_A_REG;
        bus.ALUSrcB = ALU_B_IMM;
      end
      S_MEM_LOAD: begin
        bus.MemRead    = 1'b1;
        bus.mem_select = 1'b1;
      end
      S_MEM_STORE: begin
        bus.MemWrite   = 1'b1;
        bus.mem_select = 1'b1;
      end
      S_MEM_WB: begin
        bus.RegWrite   = 1'b1;
        bus.MemToReg   = DATA_SELECT_MEM;
        bus.RegDst     = REG_DST_RN;
        bus.mem_select = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = ALU_A_REG;
        bus.ALUSrcB     = ALU_B_REG;
        bus.ALUOp       = ALU_OP_WIDTH'(ALU_OP_SUB);
        bus.PCWriteCond = 1'b1;
        bus.PCWrite     = bus.alu_zero | bus.alu_neg;
        bus.PCSource    = (bus.alu_zero | bus.alu_neg) ? PC_SELECT_ALU_BUF : PC_SELECT_RESET;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = PC_SELECT_JUMP;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_v2.sv
// tb_multicycle_control_v2: directed and randomized check of the control FSM against an instruction-step model
module tb_multicycle_control_v2;
  import multicycle_control_v2_pkg::ALU_OP_ADD;
  import multicycle_control_v2_pkg::ALU_OP_SUB;
  localparam int TO = 15;
  typedef struct packed {
    logic [3:0] st;
    logic       err, hlt;
    logic       regdst, alusrca, regwrite, memtoreg, irwrite, memwrite, memread, pcwrite, pcwritecond, memsel;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
  } outs_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  multicycle_control_v2_if bus();
  multicycle_control_v2 dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0, errors = 0;
  int m_ph = 0, m_k = 0, m_w = 0;
  logic [3:0] m_op = 4'd0;
  bit m_valid = 0, m_loaded = 0;
  outs_t obs;
  logic [3:0] q_ops[$];
  // state visited at step k of an instruction (step 0 is decode); -1 once the instruction is done
  function automatic int step_state(logic [3:0] op, int k);
    case (op)
      4'd1, 4'd3: return k == 1 ? 3 : (k == 2 ? 5 : -1);
      4'd2:       return k == 1 ? 4 : (k == 2 ? 5 : -1);
      4'd5:       return k == 1 ? 6 : (k == 2 ? 8 : (k == 3 ? 10 : -1));
      4'd6:       return k == 1 ? 7 : (k == 2 ? 9 : -1);
      4'd8:       return k == 1 ? 11 : -1;
      4'd9:       return k == 1 ? 12 : -1;
      default:    return -1;
    endcase
  endfunction
  function automatic int m_state();
    case (m_ph)
      0: return 0;
      1: return 1;
      2: return m_k == 0 ? 2 : step_state(m_op, m_k);
      3: return 14;
      default: return 15;
    endcase
  endfunction
  function automatic outs_t expect_outs(logic rdy, logic z, logic n);
    outs_t e;
    int st;
    e = '0;
    st = m_state();
    e.st = 4'(st);
    case (st)
      0: begin e.memread = 1; e.pcwrite = 1; end
      1: begin e.memread = 1; e.srcb = 2'd1; e.aluop = ALU_OP_ADD; e.pcsrc = 2'd1; e.irwrite = rdy; e.pcwrite = rdy; end
      2: begin e.srcb = 2'd3; e.aluop = ALU_OP_ADD; end
      3: begin e.alusrca = 1; e.regdst = 1; e.aluop = (m_op == 4'd3) ? ALU_OP_SUB : ALU_OP_ADD; end
      4, 6, 7: begin e.alusrca = 1; e.srcb = 2'd2; e.aluop = ALU_OP_ADD; end
      5: begin e.regwrite = 1; e.regdst = (m_op != 4'd2); end
      8: begin e.memread = 1; e.memsel = 1; end
      9: begin e.memwrite = 1; e.memsel = 1; end
      10: begin e.regwrite = 1; e.memtoreg = 1; e.memsel = 1; end
      11: begin e.alusrca = 1; e.aluop = ALU_OP_SUB; e.pcwritecond = 1; e.pcwrite = z | n; e.pcsrc = (z | n) ? 2'd2 : 2'd0; end
      12: begin e.pcwrite = 1; e.pcsrc = 2'd3; end
      14: e.hlt = 1;
      15: e.err = 1;
      default: ;
    endcase
    return e;
  endfunction
  function automatic outs_t sample();
    outs_t o;
    o.st = bus.state_out; o.err = bus.error; o.hlt = bus.halted;
    o.regdst = bus.RegDst; o.alusrca = bus.ALUSrcA; o.regwrite = bus.RegWrite; o.memtoreg = bus.MemToReg;
    o.irwrite = bus.IRWrite; o.memwrite = bus.MemWrite; o.memread = bus.MemRead; o.pcwrite = bus.PCWrite;
    o.pcwritecond = bus.PCWriteCond; o.memsel = bus.mem_select; o.srcb = bus.ALUSrcB; o.aluop = bus.ALUOp;
    o.pcsrc = bus.PCSource;
    return o;
  endfunction
  // advance the instruction-level model across one clock edge
  function automatic void model_step(logic rn, logic rdy);
    int st;
    if (!rn) begin m_ph = 0; m_w = 0; m_valid = 1; return; end
    if (!m_valid) return;
    case (m_ph)
      0: begin m_ph = 1; m_w = 0; end
      1: if (rdy) begin m_ph = 2; m_k = 0; m_w = 0; m_loaded = 1; end
         else if (m_w == TO) m_ph = 4;
         else m_w++;
      2: if (m_k == 0) begin
           if (m_op == 4'd15) m_ph = 3;
           else if (!(m_op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd8, 4'd9})) m_ph = 4;
           else if (step_state(m_op, 1) < 0) m_ph = 1;
           else m_k = 1;
         end else begin
           st = step_state(m_op, m_k);
           if ((st == 8 || st == 9) && !rdy) begin
             if (m_w == TO) m_ph = 4; else m_w++;
           end else begin
             m_w = 0;
             if (step_state(m_op, m_k + 1) < 0) m_ph = 1; else m_k++;
           end
         end
      default: ;
    endcase
  endfunction
  function automatic logic [3:0] pick();
    int r;
    logic [3:0] legal[8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd8, 4'd9};
    logic [3:0] bad[7] = '{4'd4, 4'd7, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};
    if (q_ops.size() > 0) return q_ops.pop_front();
    r = $urandom_range(0, 99);
    if (r < 86) return legal[$urandom_range(0, 7)];
    if (r < 93) return 4'd15;
    return bad[$urandom_range(0, 6)];
  endfunction
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // one clock: drive inputs, compare every output to the model, then load a new opcode on fetch
  task automatic cycle(logic rn, logic rdy, logic z, logic n);
    outs_t e;
    @(negedge clk);
    reset = rn; bus.mem_ready = rdy; bus.alu_zero = z; bus.alu_neg = n;
    #1;
    obs = sample();
    if (m_valid) begin
      e = expect_outs(rdy, z, n);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL cycle@%0t: state got %0d expected %0d, outputs got %h expected %h", $time, obs.st, e.st, obs, e);
      end
    end
    model_step(rn, rdy);
    @(posedge clk);
    #1;
    if (m_loaded) begin bus.opcode = pick(); m_op = bus.opcode; m_loaded = 0; end
  endtask
  initial begin
    int cnt;
    logic seen;
    logic [1:0] zn[3] = '{2'b10, 2'b01, 2'b00};
    bus.opcode = 4'd0; bus.mem_ready = 1'b0; bus.alu_zero = 1'b0; bus.alu_neg = 1'b0;
    q_ops = '{4'd1, 4'd5, 4'd8, 4'd8, 4'd8, 4'd12, 4'd15, 4'd6};
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0); chk("rst_state", obs.st, 0); chk("rst_error", obs.err, 0); chk("rst_halted", obs.hlt, 0);
    cycle(1, 1, 0, 0); chk("add_if", obs.st, 1); chk("add_irwrite", obs.irwrite, 1);
    cycle(1, 1, 0, 0); chk("add_id", obs.st, 2);
    cycle(1, 1, 0, 0); chk("add_regx", obs.st, 3);
    cycle(1, 1, 0, 0); chk("add_wb", obs.st, 5); chk("add_wb_regwrite", obs.regwrite, 1); chk("add_wb_regdst", obs.regdst, 1);
    cycle(1, 1, 0, 0); chk("add_back_if", obs.st, 1); chk("add_if_regwrite", obs.regwrite, 0);
    cycle(1, 1, 0, 0); chk("lr_id", obs.st, 2);
    cycle(1, 1, 0, 0); chk("lr_addr", obs.st, 6);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin cycle(1, 0, 0, 0); cnt += (obs.st == 4'd8 && obs.memread) ? 1 : 0; end
    cycle(1, 1, 0, 0); cnt += (obs.st == 4'd8 && obs.memread) ? 1 : 0;
    chk("lr_memread_cycles", cnt, 4);
    cycle(1, 1, 0, 0); chk("lr_memwb", obs.st, 10); chk("lr_regwrite", obs.regwrite, 1); chk("lr_memtoreg", obs.memtoreg, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, 0); chk("bleq_if", obs.st, 1);
      cycle(1, 1, 0, 0); chk("bleq_id", obs.st, 2);
      cycle(1, 1, zn[i][1], zn[i][0]); chk("bleq_state", obs.st, 11);
      chk("bleq_pcwrite", obs.pcwrite, i < 2 ? 1 : 0);
      chk("bleq_pcwritecond", obs.pcwritecond, 1);
      if (i < 2) chk("bleq_pcsource", obs.pcsrc, 2);
    end
    seen = 1'b0; cnt = 0;
    for (int i = 0; i < 16; i++) begin cycle(1, 0, 0, 0); seen |= obs.irwrite; cnt += (obs.st == 4'd1) ? 1 : 0; end
    chk("timeout_if_cycles", cnt, 16); chk("timeout_irwrite", seen, 0);
    cycle(1, 0, 0, 0); chk("timeout_error_state", obs.st, 15); chk("timeout_error", obs.err, 1);
    for (int i = 0; i < 3; i++) begin cycle(1, 1, 0, 0); chk("error_hold", obs.st, 15); end
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0); chk("err_cleared", obs.err, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0); chk("illegal_id", obs.st, 2);
    cycle(1, 1, 0, 0); chk("illegal_error", obs.st, 15); chk("illegal_error_flag", obs.err, 1);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0); chk("halt_id", obs.st, 2);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 1, 1); chk("halted_flag", obs.hlt, 1); seen |= |obs[16:0];
    end
    chk("halt_strobes", seen, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0); chk("halt_cleared", obs.hlt, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0); chk("sr_id", obs.st, 2);
    cycle(1, 1, 0, 0); chk("sr_addr", obs.st, 7);
    cycle(0, 0, 0, 0); chk("sr_store", obs.st, 9); chk("sr_memwrite", obs.memwrite, 1);
    cycle(1, 1, 0, 0); chk("sr_rst_state", obs.st, 0); chk("sr_rst_memwrite", obs.memwrite, 0); chk("sr_rst_error", obs.err, 0);
    begin
      int dwell, stuck;
      logic rn, rdy;
      dwell = 0; stuck = 0;
      for (int i = 0; i < 5000; i++) begin
        dwell = (m_ph >= 3) ? dwell + 1 : 0;
        rn = !(dwell > 6 || $urandom_range(0, 249) == 0);
        if (stuck > 0) begin rdy = 1'b0; stuck--; end
        else begin
          rdy = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 149) == 0) stuck = $urandom_range(12, 20);
        end
        cycle(rn, rdy, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
